// File: rtl/sw_debounce_events.sv
// sw_debounce_events: debounces the 16 switch levels from the SPI expander client,
// publishes the clean state and one-cycle press pulses, and queues per-switch
// events in a first-word-fall-through FIFO with a valid/ready handshake.
// Optional feature macro: SW_EVT_RELEASE_EN (release events are queued as well as presses).
module sw_debounce_events #(
    parameter logic [15:0] TICK_DIV     = 16'd50000,
    parameter logic [3:0]  STABLE_TICKS = 4'd8,
    parameter int          FIFO_AW      = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] IO16_SW,
    output logic [15:0] SW_STATE,
    output logic [15:0] SW_PRESS,
    output logic        EVT_VALID,
    output logic [4:0]  EVT_DATA,
    input  logic        EVT_READY,
    output logic        EVT_OVERFLOW,
    input  logic        OVF_CLR
);

    localparam int          DEPTH     = 1 << FIFO_AW;
    localparam logic [3:0]  DC_LAST   = STABLE_TICKS - 4'd1;
    localparam logic [15:0] TICK_LAST = TICK_DIV - 16'd1;

    logic [15:0]        sync_meta;
    logic [15:0]        sync;
    logic [15:0]        presc;
    logic               tick;
    logic [3:0]         dc [16];
    logic [15:0]        flip;
    logic [15:0]        evt_flip;
    logic [15:0]        pend;
    logic [15:0]        pend_next;
    logic [15:0]        take_vec;
    logic               take_vld;
    logic [3:0]         take_idx;
    logic               push;
    logic               pop;
    logic [4:0]         push_data;
    logic               ovf_set;
    logic [4:0]         mem [DEPTH];
    logic [FIFO_AW:0]   wptr;
    logic [FIFO_AW:0]   rptr;
    logic [FIFO_AW:0]   count;
    logic               full;
    logic               empty;

    // Two-flop synchroniser on the raw switch levels.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= IO16_SW;
            sync      <= sync_meta;
        end
    end

    assign tick = (presc == TICK_LAST);

    // Sample-tick prescaler, wrapping at the terminal count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 16'd1;
        end
    end

    // Per-bit count of consecutive ticks on which the input disagrees with the clean state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) dc[i] <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (sync[i] == SW_STATE[i]) begin
                    dc[i] <= '0;
                end else if (tick) begin
                    dc[i] <= (dc[i] == DC_LAST) ? 4'd0 : dc[i] + 4'd1;
                end
            end
        end
    end

    // A bit flips on the tick that completes its run of stable disagreement.
    always_comb begin
        flip = '0;
        for (int i = 0; i < 16; i++) begin
            flip[i] = (sync[i] != SW_STATE[i]) && tick && (dc[i] == DC_LAST);
        end
    end

`ifdef SW_EVT_RELEASE_EN
    assign evt_flip = flip;
`else
    // Releases only change the clean state; they never reach the event path.
    assign evt_flip = flip & ~SW_STATE;
`endif

    // Clean state and press pulses, both registered with the flip.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            SW_STATE <= '0;
            SW_PRESS <= '0;
        end else begin
            SW_STATE <= SW_STATE ^ flip;
            SW_PRESS <= flip & ~SW_STATE;
        end
    end

    // Lowest-index pending bit is the enqueue candidate.
    always_comb begin
        take_vld = 1'b0;
        take_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pend[i]) begin
                take_vld = 1'b1;
                take_idx = i[3:0];
            end
        end
    end

    // A flip landing on the bit being taken cancels it: the pair of changes nets to nothing.
    assign take_vec  = (take_vld && !full) ? (16'd1 << take_idx) : 16'd0;
    assign push      = take_vld && !full && !evt_flip[take_idx];
    assign pend_next = (evt_flip & ~pend) | (~evt_flip & pend & ~take_vec);
    assign ovf_set   = |(evt_flip & pend);

`ifdef SW_EVT_RELEASE_EN
    assign push_data = {SW_STATE[take_idx], take_idx};
`else
    assign push_data = {1'b1, take_idx};
`endif

    // Pending-event vector.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

    // Sticky overflow flag; a new loss wins over a clear in the same cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            EVT_OVERFLOW <= 1'b0;
        end else if (ovf_set) begin
            EVT_OVERFLOW <= 1'b1;
        end else if (OVF_CLR) begin
            EVT_OVERFLOW <= 1'b0;
        end
    end

    // Fullness is judged at the start of the cycle, so a same-cycle pop never frees room for a push.
    assign count = wptr - rptr;
    assign full  = (count == (FIFO_AW + 1)'(DEPTH));
    assign empty = (wptr == rptr);
    assign pop   = !empty && EVT_READY;

    // FIFO storage; contents are data only and need no reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wptr[FIFO_AW-1:0]] <= push_data;
        end
    end

    // FIFO read and write pointers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    assign EVT_VALID = !empty;
    assign EVT_DATA  = empty ? 5'd0 : mem[rptr[FIFO_AW-1:0]];

endmodule
